lut_port_arbiter: RTL and testbench

Sequencing and sharing controller for one single-port coefficient lookup memory (14 segments × 256 bins, 3584 words) in the MD core. It accepts read requests from NUM_REQ force-evaluation pipelines and a runtime coefficient-write stream, and grants at most one memory operation per cycle. Reads are granted round-robin. It tracks in-flight reads through the memory's fixed read latency and returns each datum to its requester. Because every access goes through this block, read-during-write hazards at the memory port cannot occur.

---
 rtl/lut_port_arbiter_if.sv | 37 +++
 rtl/lut_port_arbiter.sv | 135 +++++++++++++
 tb/tb_lut_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_port_arbiter_if.sv
// Request/response, coefficient-write and memory-port bundle for lut_port_arbiter.
// slave = arbiter side, master = requesters, write source and memory side.
interface lut_port_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          rsp_err;
  logic                          wr_valid;
  logic [ADDR_WIDTH-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic                          wr_ready;
  logic                          wr_err;
  logic [ADDR_WIDTH-1:0]         lut_address;
  logic [DATA_WIDTH-1:0]         lut_data;
  logic                          lut_rden;
  logic                          lut_wren;
  logic [DATA_WIDTH-1:0]         lut_q;
  logic                          busy;

  modport slave (
    input  req_valid, req_addr, wr_valid, wr_addr, wr_data, lut_q,
    output req_ready, rsp_valid, rsp_data, rsp_err, wr_ready, wr_err,
           lut_address, lut_data, lut_rden, lut_wren, busy
  );

  modport master (
    output req_valid, req_addr, wr_valid, wr_addr, wr_data, lut_q,
    input  req_ready, rsp_valid, rsp_data, rsp_err, wr_ready, wr_err,
           lut_address, lut_data, lut_rden, lut_wren, busy
  );
endinterface

// File: rtl/lut_port_arbiter.sv
// Shares one single-port coefficient LUT between NUM_REQ round-robin readers and a
// write stream; tracks in-flight reads through the memory latency and routes data back.
module lut_port_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DEPTH      = 3584,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned WR_MAX     = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  lut_port_arbiter_if.slave  bus
);

  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned RUN_W = $clog2(WR_MAX + 1);
  localparam int unsigned TAG_D = RD_LATENCY + 1;
  localparam int unsigned AW1   = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = AW1'(DEPTH);

  logic [ID_W-1:0]       r_last_gnt;
  logic [RUN_W-1:0]      r_wr_run;
  logic [TAG_D-1:0]      r_tag_v;
  logic [TAG_D-1:0]      r_tag_err;
  logic [ID_W-1:0]       r_tag_id [TAG_D];

  logic                  w_rd_pending;
  logic                  w_rd_found;
  logic                  w_wr_gnt;
  logic                  w_rd_gnt;
  logic                  w_rd_inr;
  logic                  w_wr_inr;
  logic [ID_W-1:0]       w_rd_idx;
  logic [ID_W-1:0]       w_cand;
  logic [ADDR_WIDTH-1:0] w_rd_addr;

  // Round-robin search starting one past the last accepted requester.
  always_comb begin
    w_rd_found = 1'b0;
    w_rd_idx   = '0;
    w_cand     = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_cand = ID_W'((32'(r_last_gnt) + k) % NUM_REQ);
      if (!w_rd_found && bus.req_valid[w_cand]) begin
        w_rd_found = 1'b1;
        w_rd_idx   = w_cand;
      end
    end
  end

  assign w_rd_addr    = bus.req_addr[32'(w_rd_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_rd_pending = |bus.req_valid;
  assign w_rd_inr     = {1'b0, w_rd_addr} < DEPTH_LIM;
  assign w_wr_inr     = {1'b0, bus.wr_addr} < DEPTH_LIM;

  // Writes win unless they have already held the port for WR_MAX cycles over a waiting read.
  assign w_wr_gnt = reset_n & bus.wr_valid &
                    ((r_wr_run < RUN_W'(WR_MAX)) | ~w_rd_pending);
  assign w_rd_gnt = reset_n & ~w_wr_gnt & w_rd_found;

  assign bus.wr_ready = w_wr_gnt;
  assign bus.busy     = |r_tag_v;

  always_comb begin
    bus.req_ready = '0;
    if (w_rd_gnt) bus.req_ready[w_rd_idx] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_gnt <= ID_W'(NUM_REQ - 1);
      r_wr_run   <= '0;
    end else begin
      if (w_rd_gnt) r_last_gnt <= w_rd_idx;
      if (w_wr_gnt && w_rd_pending) r_wr_run <= r_wr_run + RUN_W'(1);
      else                          r_wr_run <= '0;
    end
  end

  // Memory port: at most one enable per cycle; address/data hold when idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.lut_address <= '0;
      bus.lut_data    <= '0;
      bus.lut_rden    <= 1'b0;
      bus.lut_wren    <= 1'b0;
      bus.wr_err      <= 1'b0;
    end else begin
      bus.lut_rden <= 1'b0;
      bus.lut_wren <= 1'b0;
      bus.wr_err   <= 1'b0;
      if (w_wr_gnt) begin
        if (w_wr_inr) begin
          bus.lut_address <= bus.wr_addr;
          bus.lut_data    <= bus.wr_data;
          bus.lut_wren    <= 1'b1;
        end else begin
          bus.wr_err <= 1'b1;
        end
      end else if (w_rd_gnt && w_rd_inr) begin
        bus.lut_address <= w_rd_addr;
        bus.lut_rden    <= 1'b1;
      end
    end
  end

  // Tag pipeline aligned so its last stage coincides with valid lut_q.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tag_v   <= '0;
      r_tag_err <= '0;
      for (int unsigned i = 0; i < TAG_D; i++) r_tag_id[i] <= '0;
    end else begin
      r_tag_v     <= {r_tag_v[TAG_D-2:0], w_rd_gnt};
      r_tag_err   <= {r_tag_err[TAG_D-2:0], ~w_rd_inr};
      r_tag_id[0] <= w_rd_idx;
      for (int unsigned i = 1; i < TAG_D; i++) r_tag_id[i] <= r_tag_id[i-1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.rsp_valid <= '0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_data  <= '0;
    end else begin
      bus.rsp_valid <= '0;
      if (r_tag_v[TAG_D-1]) bus.rsp_valid[r_tag_id[TAG_D-1]] <= 1'b1;
      bus.rsp_err  <= r_tag_v[TAG_D-1] & r_tag_err[TAG_D-1];
      bus.rsp_data <= (r_tag_v[TAG_D-1] && !r_tag_err[TAG_D-1]) ? bus.lut_q : '0;
    end
  end

endmodule

// File: tb/tb_lut_port_arbiter.sv
// Bench for lut_port_arbiter: memory model, shadow-memory scoreboard of read responses,
// per-cycle checks of the memory port and grant behaviour.
module tb_lut_port_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned DW      = 32;
  localparam int unsigned AW      = 12;
  localparam int unsigned DEPTH   = 3584;
  localparam int unsigned RSP_LAT = 3;

  typedef struct packed {
    logic [1:0]  id;
    logic        err;
    logic [31:0] data;
    logic [31:0] t;
  } sb_t;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  lut_port_arbiter_if #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  lut_port_arbiter #(
    .NUM_REQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .DEPTH(DEPTH), .RD_LATENCY(2), .WR_MAX(8)
  ) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  sb_t         sb[$];
  int          gnt_log[$];
  int          n_err = 0;
  int          n_chk = 0;
  logic [31:0] cyc = '0;
  logic [31:0] sh  [0:4095];
  logic [31:0] mem [0:4095];
  logic        mem_v;
  logic [11:0] mem_a;
  logic [31:0] mem_q;
  logic        exp_rden, exp_wren, exp_wr_err;
  logic [11:0] exp_addr;
  logic [31:0] exp_data;

  function automatic logic [31:0] init_word(input int i);
    return (i == 5) ? 32'h3F80_0000 : (32'hC0DE_0000 | 32'(i));
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Two-stage memory: address register then output register.
  initial begin
    mem_v <= 1'b0;
    mem_a <= '0;
    mem_q <= '0;
    for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
    forever begin
      @(posedge clock);
      if (bus.lut_wren) mem[bus.lut_address] <= bus.lut_data;
      mem_v <= bus.lut_rden;
      mem_a <= bus.lut_address;
      if (mem_v) mem_q <= mem[mem_a];
    end
  end
  assign bus.lut_q = mem_q;

  task automatic check_rsp();
    sb_t        e;
    logic [3:0] oh;
    check_eq("lut_excl", 64'(bus.lut_rden & bus.lut_wren), 64'(0));
    if (|bus.rsp_valid) begin
      if (sb.size() == 0) begin
        check_eq("rsp_unexpected", 64'(bus.rsp_valid), 64'(0));
      end else begin
        e  = sb.pop_front();
        oh = '0;
        oh[e.id] = 1'b1;
        check_eq("rsp_id", 64'(bus.rsp_valid), 64'(oh));
        check_eq("rsp_data", 64'(bus.rsp_data), 64'(e.data));
        check_eq("rsp_err", 64'(bus.rsp_err), 64'(e.err));
        check_eq("rsp_latency", 64'(cyc - e.t), 64'(RSP_LAT));
      end
    end
  endtask

  always @(negedge clock) begin
    cyc <= cyc + 32'd1;
    check_rsp();
  end

  task automatic set_addr(input int i, input logic [11:0] a);
    bus.req_addr[i*AW +: AW] = a;
  endtask

  // Check last cycle's memory-port expectations, then record this cycle's grants.
  task automatic tick();
    logic [11:0] a;
    sb_t         e;
    #2;
    if (!reset_n) begin
      check_eq("rst_rden", 64'(bus.lut_rden), 64'(0));
      check_eq("rst_wren", 64'(bus.lut_wren), 64'(0));
      check_eq("rst_ready", 64'({bus.wr_ready, bus.req_ready}), 64'(0));
      exp_rden = 1'b0; exp_wren = 1'b0; exp_wr_err = 1'b0;
    end else begin
      check_eq("lut_rden", 64'(bus.lut_rden), 64'(exp_rden));
      check_eq("lut_wren", 64'(bus.lut_wren), 64'(exp_wren));
      check_eq("wr_err", 64'(bus.wr_err), 64'(exp_wr_err));
      if (exp_rden || exp_wren) check_eq("lut_address", 64'(bus.lut_address), 64'(exp_addr));
      if (exp_wren) check_eq("lut_data", 64'(bus.lut_data), 64'(exp_data));
      check_eq("one_grant", 64'($countones({bus.wr_ready, bus.req_ready}) <= 1), 64'(1));
      exp_rden = 1'b0; exp_wren = 1'b0; exp_wr_err = 1'b0;
      if (bus.wr_valid && bus.wr_ready) begin
        gnt_log.push_back(-1);
        if (bus.wr_addr < 12'(DEPTH)) begin
          sh[bus.wr_addr] = bus.wr_data;
          exp_wren = 1'b1;
          exp_addr = bus.wr_addr;
          exp_data = bus.wr_data;
        end else begin
          exp_wr_err = 1'b1;
        end
      end
      for (int i = 0; i < int'(NREQ); i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          a      = bus.req_addr[i*AW +: AW];
          e.id   = 2'(i);
          e.err  = (a >= 12'(DEPTH));
          e.data = e.err ? 32'h0 : sh[a];
          e.t    = cyc;
          sb.push_back(e);
          gnt_log.push_back(i);
          if (!e.err) begin
            exp_rden = 1'b1;
            exp_addr = a;
          end
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    check_eq("drain_pending", 64'(sb.size()), 64'(0));
  endtask

  // Called at a falling edge; returns at a falling edge with reset released.
  task automatic do_reset();
    #1 reset_n = 1'b0;
    sb.delete();
    #1;
    check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check_eq("rst_rsp_err", 64'(bus.rsp_err), 64'(0));
    check_eq("rst_rsp_data", 64'(bus.rsp_data), 64'(0));
    check_eq("rst_busy", 64'(bus.busy), 64'(0));
    check_eq("rst_wr_err", 64'(bus.wr_err), 64'(0));
    check_eq("rst_lut_en", 64'({bus.lut_rden, bus.lut_wren}), 64'(0));
    check_eq("rst_lut_address", 64'(bus.lut_address), 64'(0));
    check_eq("rst_lut_data", 64'(bus.lut_data), 64'(0));
    check_eq("rst_ready_now", 64'({bus.wr_ready, bus.req_ready}), 64'(0));
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_g;
    reset_n       = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    exp_rden = 1'b0; exp_wren = 1'b0; exp_wr_err = 1'b0;
    exp_addr = '0;   exp_data = '0;
    for (int i = 0; i < 4096; i++) sh[i] = init_word(i);
    @(negedge clock);
    do_reset();

    // Single read from requester 2, word 5.
    bus.req_valid = 4'b0100;
    set_addr(2, 12'h005);
    #1 check_eq("single_ready", 64'(bus.req_ready), 64'(4'b0100));
    tick();
    bus.req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      #1 check_eq("single_busy", 64'(bus.busy), 64'(k < 3));
      tick();
    end

    // Round-robin from reset.
    do_reset();
    for (int i = 0; i < 4; i++) set_addr(i, 12'(12'h010 + i));
    bus.req_valid = 4'b1111;
    gnt_log.delete();
    repeat (8) tick();
    bus.req_valid = '0;
    check_eq("rr_len", 64'(gnt_log.size()), 64'(8));
    for (int k = 0; k < 8 && k < gnt_log.size(); k++)
      check_eq("rr_order", 64'(gnt_log[k]), 64'(k % 4));
    drain();

    // Write then read-back of the same word.
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 12'h0FF;
    bus.wr_data  = 32'hDEAD_BEEF;
    tick();
    bus.wr_valid  = 1'b0;
    bus.req_valid = 4'b0010;
    set_addr(1, 12'h0FF);
    tick();
    bus.req_valid = '0;
    drain();

    // Write stream starving requester 0.
    do_reset();
    gnt_log.delete();
    bus.req_valid = 4'b0001;
    set_addr(0, 12'h020);
    bus.wr_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.wr_addr = 12'(12'h100 + k);
      bus.wr_data = $urandom;
      tick();
    end
    bus.wr_valid  = 1'b0;
    bus.req_valid = '0;
    check_eq("starve_len", 64'(gnt_log.size()), 64'(20));
    for (int k = 0; k < 20 && k < gnt_log.size(); k++) begin
      exp_g = (k == 8 || k == 17) ? 0 : -1;
      check_eq("starve_gnt", 64'(gnt_log[k]), 64'(exp_g));
    end
    drain();

    // Out-of-range read, last valid word, out-of-range write.
    bus.req_valid = 4'b1000;
    set_addr(3, 12'hE00);
    tick();
    bus.req_valid = '0;
    drain();
    bus.req_valid = 4'b1000;
    set_addr(3, 12'hDFF);
    tick();
    bus.req_valid = '0;
    drain();
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 12'hFA0;
    bus.wr_data  = 32'h1234_5678;
    tick();
    bus.wr_valid = 1'b0;
    tick();
    tick();

    // Reset while three reads are in flight.
    do_reset();
    bus.req_valid = 4'b0111;
    for (int i = 0; i < 3; i++) set_addr(i, 12'(12'h030 + i));
    repeat (3) tick();
    bus.req_valid = '0;
    tick();
    bus.req_valid = 4'b1111;
    bus.wr_valid  = 1'b1;
    do_reset();
    bus.wr_valid = 1'b0;
    #1 check_eq("post_rst_first", 64'(bus.req_ready), 64'(4'b0001));
    tick();
    bus.req_valid = '0;
    drain();
    repeat (4) tick();

    // Random mix of reads, writes and out-of-range addresses.
    for (int k = 0; k < 80; k++) begin
      bus.req_valid = 4'($urandom);
      for (int i = 0; i < 4; i++)
        set_addr(i, ($urandom_range(0, 9) == 0) ? 12'($urandom_range(3584, 4095))
                                                 : 12'($urandom_range(0, 31)));
      bus.wr_valid = ($urandom_range(0, 2) == 0);
      bus.wr_addr  = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(3584, 4095))
                                                 : 12'($urandom_range(0, 31));
      bus.wr_data  = $urandom;
      tick();
    end
    bus.req_valid = '0;
    bus.wr_valid  = 1'b0;
    drain();
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
